keccak_squeeze: RTL and testbench
=================================

// Module: keccak_squeeze
// PURPOSE
// Squeeze-side reader for the Keccak-f[1600] permutation. Accepts a permuted 1600-bit state,
// streams its rate lanes out as 64-bit words over a valid/ready stream, and, for outputs longer
// than one rate block (SHAKE/XOF), returns the full state to the permutation for another round
// set before continuing. Sits between keccakf1600_statepermutate and the digest consumer.
// PARAMETERS
// RATE_LANES  17  lanes per rate block (17 = SHA3-256/SHAKE256, 21 = SHAKE128); 1..24
// LEN_W       16  width of the requested output length in lanes
// PORTS
// clk          in   1     clock; all logic on posedge
// rstn         in   1     synchronous active-low reset
// cmd_valid    in   1     squeeze request valid
// cmd_ready    out  1     high only in IDLE
// cmd_len      in   LEN_W total output lanes requested, sampled at cmd handshake
// st_valid     in   1     permuted state valid, from permutation
// st_ready     out  1     high only in WAIT_ST
// st_data      in   1600  state; lane i = st_data[64*i +: 64], i = x + 5*y
// perm_valid   out  1     request another permutation of perm_state
// perm_ready   in   1     permutation accepts perm_state
// perm_state   out  1600  captured full state (rate + capacity), unchanged
// dout_valid   out  1     output lane valid
// dout_ready   in   1     consumer accepts lane
// dout_data    out  64    output lane
// dout_last    out  1     final lane of the request
// done         out  1     one-cycle pulse when request complete
// BEHAVIOUR
// - Reset (rstn=0 at posedge): state IDLE; all outputs 0 except cmd_ready=1; counters 0.
//   Reset mid-operation abandons the request; no further dout/perm traffic.
// - FSM: IDLE -cmd hs, len>0-> WAIT_ST; IDLE -cmd hs, len=0-> IDLE with done pulse next cycle.
//   WAIT_ST -st hs-> EMIT (state captured, lane index=0).
//   EMIT: one lane per dout handshake; remaining-=1, index+=1.
//     remaining hits 0 -> IDLE, done=1 for one cycle (cycle after last hs).
//     index hits RATE_LANES with remaining>0 -> REQ_PERM.
//   REQ_PERM: perm_valid=1, perm_state=captured state; on perm hs -> WAIT_ST.
// - Latency: st hs at cycle N -> dout_valid with lane 0 at N+1; full throughput 1 lane/cycle.
// - dout_valid/dout_data/dout_last held stable until dout_ready; dout_last=1 iff remaining==1.
// - perm_valid/perm_state held stable until perm_ready. st_valid outside WAIT_ST ignored.
// - remaining exactly RATE_LANES: all lanes emitted, no permutation request.
// - cmd_len counts lanes modulo 2^LEN_W; no wrap inside a request.
// CONFIGURATION
// KECCAK_SQUEEZE_BYTESWAP_EN defined: dout_data is byte-reversed lane (big-endian byte order).
// Undefined: dout_data = lane as stored (little-endian, FIPS 202 byte order). perm_state never swapped.
// TESTING
// - T1: cmd_len=4, st lane i = 64'hi, dout_ready=1 -> dout 0,1,2,3, last on 3, done once, no perm_valid.
// - T2: cmd_len=20, RATE_LANES=17 -> lanes 0..16, perm_valid with perm_state==st_data; new state
//   lanes 100+i -> dout 100,101,102, last on 102, done.
// - T3: cmd_len=17 -> lanes 0..16, last on 16, perm_valid never asserted.
// - T4: backpressure: dout_ready toggled 1,0,0,1 -> data/last stable while stalled, no lane lost/duped.
// - T5: cmd_len=0 -> cmd accepted, done pulse, no dout_valid, st_ready never high.
// - T6: rstn=0 during EMIT at lane 5 -> next cycle IDLE, dout_valid=0, cmd_ready=1; BYTESWAP build:
//   lane 64'h0102030405060708 -> dout 64'h0807060504030201.

Source files
------------

// File: rtl/keccak_squeeze.sv
// Squeeze-side reader for Keccak-f[1600]: streams rate lanes of a permuted state as 64-bit words
// and hands the full state back for re-permutation on long (XOF) outputs. Option: KECCAK_SQUEEZE_BYTESWAP_EN.
module keccak_squeeze #(
  parameter int RATE_LANES = 17,
  parameter int LEN_W      = 16
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             st_valid,
  output logic             st_ready,
  input  logic [1599:0]    st_data,
  output logic             perm_valid,
  input  logic             perm_ready,
  output logic [1599:0]    perm_state,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic [63:0]      dout_data,
  output logic             dout_last,
  output logic             done
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_ST  = 2'd1,
    EMIT     = 2'd2,
    REQ_PERM = 2'd3
  } state_t;

  localparam logic [4:0]       LAST_IDX = 5'(RATE_LANES - 1);
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

  // Output byte order of a lane; the captured state itself is never reordered.
  function automatic logic [63:0] lane_order(input logic [63:0] lane);
`ifdef KECCAK_SQUEEZE_BYTESWAP_EN
    for (int b = 0; b < 8; b++) begin
      lane_order[8*b +: 8] = lane[8*(7-b) +: 8];
    end
`else
    lane_order = lane;
`endif
  endfunction

  state_t             state_r;
  logic [LEN_W-1:0]   rem_r;
  logic [4:0]         idx_r;
  logic [1599:0]      st_r;
  logic               cmd_ready_r;
  logic               st_ready_r;
  logic               perm_valid_r;
  logic               dout_valid_r;
  logic [63:0]        dout_data_r;
  logic               dout_last_r;
  logic               done_r;

  logic [4:0]         next_idx_s;
  logic [LEN_W-1:0]   rem_dec_s;
  logic [63:0]        next_lane_s;

  // Lane that follows the one currently presented, and the decremented remaining count.
  always_comb begin
    next_idx_s  = idx_r + 5'd1;
    rem_dec_s   = rem_r - LEN_ONE;
    next_lane_s = st_r[{next_idx_s, 6'd0} +: 64];
  end

  // Control FSM with registered handshake outputs; remaining/index counters advance per lane.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_r      <= IDLE;
      rem_r        <= LEN_ZERO;
      idx_r        <= 5'd0;
      st_r         <= {1600{1'b0}};
      cmd_ready_r  <= 1'b1;
      st_ready_r   <= 1'b0;
      perm_valid_r <= 1'b0;
      dout_valid_r <= 1'b0;
      dout_data_r  <= 64'd0;
      dout_last_r  <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cmd_valid) begin
            if (cmd_len == LEN_ZERO) begin
              done_r <= 1'b1;
            end else begin
              rem_r       <= cmd_len;
              cmd_ready_r <= 1'b0;
              st_ready_r  <= 1'b1;
              state_r     <= WAIT_ST;
            end
          end
        end
        WAIT_ST: begin
          if (st_valid) begin
            st_r         <= st_data;
            idx_r        <= 5'd0;
            st_ready_r   <= 1'b0;
            dout_valid_r <= 1'b1;
            dout_data_r  <= lane_order(st_data[63:0]);
            dout_last_r  <= (rem_r == LEN_ONE);
            state_r      <= EMIT;
          end
        end
        EMIT: begin
          if (dout_ready) begin
            rem_r <= rem_dec_s;
            if (rem_dec_s == LEN_ZERO) begin
              idx_r        <= 5'd0;
              dout_valid_r <= 1'b0;
              dout_data_r  <= 64'd0;
              dout_last_r  <= 1'b0;
              done_r       <= 1'b1;
              cmd_ready_r  <= 1'b1;
              state_r      <= IDLE;
            end else if (idx_r == LAST_IDX) begin
              // Rate block exhausted with output still owed: send the whole state back.
              idx_r        <= 5'd0;
              dout_valid_r <= 1'b0;
              dout_data_r  <= 64'd0;
              dout_last_r  <= 1'b0;
              perm_valid_r <= 1'b1;
              state_r      <= REQ_PERM;
            end else begin
              idx_r       <= next_idx_s;
              dout_data_r <= lane_order(next_lane_s);
              dout_last_r <= (rem_dec_s == LEN_ONE);
            end
          end
        end
        REQ_PERM: begin
          if (perm_ready) begin
            perm_valid_r <= 1'b0;
            st_ready_r   <= 1'b1;
            state_r      <= WAIT_ST;
          end
        end
        default: begin
          state_r      <= IDLE;
          rem_r        <= LEN_ZERO;
          idx_r        <= 5'd0;
          cmd_ready_r  <= 1'b1;
          st_ready_r   <= 1'b0;
          perm_valid_r <= 1'b0;
          dout_valid_r <= 1'b0;
          dout_data_r  <= 64'd0;
          dout_last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready  = cmd_ready_r;
  assign st_ready   = st_ready_r;
  assign perm_valid = perm_valid_r;
  assign perm_state = st_r;
  assign dout_valid = dout_valid_r;
  assign dout_data  = dout_data_r;
  assign dout_last  = dout_last_r;
  assign done       = done_r;

endmodule

// File: tb/tb_keccak_squeeze.sv
// Directed bench for keccak_squeeze: expected lanes are queued as stimulus is issued and
// compared in order at each output handshake; counters track done/perm/st_ready activity.
module tb_keccak_squeeze;
  localparam int RL = 17;
  localparam int LW = 16;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [LW-1:0] cmd_len = '0;
  logic          st_valid = 1'b0;
  logic [1599:0] st_data = '0;
  logic          perm_ready = 1'b0;
  logic          dout_ready = 1'b0;
  logic          cmd_ready, st_ready, perm_valid, dout_valid, dout_last, done;
  logic [1599:0] perm_state;
  logic [63:0]   dout_data;

  keccak_squeeze #(.RATE_LANES(RL), .LEN_W(LW)) dut (
    .clk(clk), .rstn(rstn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len),
    .st_valid(st_valid), .st_ready(st_ready), .st_data(st_data),
    .perm_valid(perm_valid), .perm_ready(perm_ready), .perm_state(perm_state),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_last(dout_last), .done(done)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int fail_cnt = 0;
  logic [64:0] exp_q[$];
  int dv_cnt = 0, perm_hi_cnt = 0, st_rdy_cnt = 0, done_cnt = 0, stall_cnt = 0;
  logic        stall_r = 1'b0;
  logic [63:0] stall_data = '0;
  logic        stall_last = 1'b0;

  function automatic logic [63:0] exp_lane(input logic [63:0] v);
`ifdef KECCAK_SQUEEZE_BYTESWAP_EN
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = v[8*(7-b) +: 8];
    return r;
`else
    return v;
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pop on each handshake, stall stability, activity counters.
  always @(negedge clk) begin
    if (rstn) begin
      if (dout_valid) dv_cnt++;
      if (perm_valid) perm_hi_cnt++;
      if (st_ready) st_rdy_cnt++;
      if (done) done_cnt++;
      if (stall_r) begin
        stall_cnt++;
        chk("stall_valid", 64'(dout_valid), 64'd1);
        chk("stall_data", dout_data, stall_data);
        chk("stall_last", 64'(dout_last), 64'(stall_last));
      end
      if (dout_valid && dout_ready) begin
        chk("lane_expected", 64'(exp_q.size() != 0), 64'd1);
        if (exp_q.size() != 0) begin
          logic [64:0] e;
          e = exp_q.pop_front();
          chk("dout_data", dout_data, e[63:0]);
          chk("dout_last", 64'(dout_last), 64'(e[64]));
        end
      end
      stall_r    = dout_valid && !dout_ready;
      stall_data = dout_data;
      stall_last = dout_last;
    end else begin
      stall_r = 1'b0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [1599:0] make_state(input int base);
    logic [1599:0] s;
    for (int i = 0; i < 25; i++) s[64*i +: 64] = 64'(base + i);
    return s;
  endfunction

  task automatic push_exp(input logic [1599:0] s, input int n, input bit last_on_end);
    for (int j = 0; j < n; j++)
      exp_q.push_back({(last_on_end && (j == n - 1)), exp_lane(s[64*j +: 64])});
  endtask

  task automatic clr_cnt();
    dv_cnt = 0; perm_hi_cnt = 0; st_rdy_cnt = 0; done_cnt = 0; stall_cnt = 0;
  endtask

  task automatic do_cmd(input int len);
    int k;
    cmd_len = LW'(len);
    cmd_valid = 1'b1;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (cmd_ready) break;
      k++;
    end
    chk("cmd_accept", 64'(k < 50), 64'd1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic give_state(input logic [1599:0] s);
    int k;
    st_data = s;
    st_valid = 1'b1;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      if (st_ready) break;
      k++;
    end
    chk("st_accept", 64'(k < 50), 64'd1);
    @(posedge clk); #1;
    st_valid = 1'b0;
  endtask

  task automatic wait_idle(input int target_done);
    int k;
    k = 0;
    while (k < 300 && !(exp_q.size() == 0 && done_cnt >= target_done)) begin
      @(negedge clk);
      k++;
    end
    repeat (3) @(posedge clk);
    #1;
    chk("done_count", 64'(done_cnt), 64'(target_done));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    logic [1599:0] s0, s1, s2, s3;
    logic [3:0] pat;
    int k;
    s0 = make_state(0);
    s1 = make_state(100);
    s2 = make_state(200);
    s3 = make_state(300);
    s3[63:0] = 64'h0102030405060708;
    pat = 4'b1001;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_st_ready", 64'(st_ready), 64'd0);
    chk("rst_dout_valid", 64'(dout_valid), 64'd0);
    chk("rst_perm_valid", 64'(perm_valid), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_dout_last", 64'(dout_last), 64'd0);
    chk("rst_perm_state", 64'(perm_state === '0), 64'd1);
    @(posedge clk); #1;
    rstn = 1'b1;
    dout_ready = 1'b1;

    // T1: short request
    clr_cnt();
    push_exp(s0, 4, 1'b1);
    do_cmd(4);
    give_state(s0);
    wait_idle(1);
    chk("t1_perm_valid_seen", 64'(perm_hi_cnt), 64'd0);
    chk("t1_lanes", 64'(dv_cnt), 64'd4);

    // T2: request spanning two rate blocks
    clr_cnt();
    push_exp(s0, RL, 1'b0);
    push_exp(s1, 3, 1'b1);
    do_cmd(20);
    give_state(s0);
    k = 0;
    while (k < 100) begin
      @(negedge clk);
      if (perm_valid) break;
      k++;
    end
    chk("t2_perm_req", 64'(k < 100), 64'd1);
    chk("t2_perm_state", 64'(perm_state === s0), 64'd1);
    chk("t2_q_at_perm", 64'(exp_q.size()), 64'd3);
    chk("t2_dout_idle", 64'(dout_valid), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("t2_perm_hold", 64'(perm_valid), 64'd1);
    chk("t2_perm_state_hold", 64'(perm_state === s0), 64'd1);
    perm_ready = 1'b1;
    @(posedge clk); #1;
    perm_ready = 1'b0;
    give_state(s1);
    wait_idle(1);

    // T3: exactly one rate block, no permutation
    clr_cnt();
    push_exp(s0, RL, 1'b1);
    do_cmd(RL);
    give_state(s0);
    wait_idle(1);
    chk("t3_perm_valid_seen", 64'(perm_hi_cnt), 64'd0);

    // T4: backpressure
    clr_cnt();
    dout_ready = 1'b0;
    push_exp(s2, 6, 1'b1);
    do_cmd(6);
    give_state(s2);
    for (int i = 0; i < 24; i++) begin
      dout_ready = pat[i % 4];
      @(posedge clk); #1;
    end
    dout_ready = 1'b1;
    wait_idle(1);
    chk("t4_stalls_seen", 64'(stall_cnt != 0), 64'd1);
    chk("t4_lanes_accepted_once", 64'(exp_q.size()), 64'd0);

    // T5: zero-length request
    clr_cnt();
    do_cmd(0);
    repeat (3) @(posedge clk);
    #1;
    chk("t5_done", 64'(done_cnt), 64'd1);
    chk("t5_dout_valid", 64'(dv_cnt), 64'd0);
    chk("t5_st_ready", 64'(st_rdy_cnt), 64'd0);

    // T6: reset while emitting lane 5
    clr_cnt();
    push_exp(s0, 10, 1'b1);
    do_cmd(10);
    give_state(s0);
    k = 0;
    while (k < 50) begin
      if (dout_valid && dout_data === exp_lane(s0[64*5 +: 64])) break;
      @(posedge clk); #1;
      k++;
    end
    chk("t6_reached_lane5", 64'(k < 50), 64'd1);
    rstn = 1'b0;
    dout_ready = 1'b0;
    @(posedge clk); #1;
    chk("t6_dout_valid", 64'(dout_valid), 64'd0);
    chk("t6_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("t6_st_ready", 64'(st_ready), 64'd0);
    chk("t6_perm_valid", 64'(perm_valid), 64'd0);
    chk("t6_q_at_reset", 64'(exp_q.size()), 64'd5);
    exp_q.delete();
    rstn = 1'b1;
    clr_cnt();
    dout_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("t6_no_dout_after", 64'(dv_cnt), 64'd0);
    chk("t6_no_done_after", 64'(done_cnt), 64'd0);
    chk("t6_no_perm_after", 64'(perm_hi_cnt), 64'd0);

    // T7: byte order of a known lane
    clr_cnt();
`ifdef KECCAK_SQUEEZE_BYTESWAP_EN
    exp_q.push_back({1'b1, 64'h0807060504030201});
`else
    exp_q.push_back({1'b1, 64'h0102030405060708});
`endif
    do_cmd(1);
    give_state(s3);
    wait_idle(1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
